// File: rtl/complex_nr_op_driver_pkg.sv
// Shared encodings for the complex multiplier operand driver: FSM states,
// operand slot positions and the result word width.
package complex_nr_op_driver_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    OUTPUT   = 2'd3
  } state_t;

  localparam int RE_A = 0;
  localparam int IM_A = 1;
  localparam int RE_B = 2;
  localparam int IM_B = 3;

  function automatic int res_w(input int data_width);
    return 4 * data_width + 3;
  endfunction

endpackage

// File: rtl/complex_op_packer.sv
// Byte-to-word assembler: four operand bytes land in fixed slots, re_a ends
// up in the MSBs of the packed word.
module complex_op_packer
  import complex_nr_op_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [4*DATA_WIDTH-1:0] op_word,
  output logic                    word_full
);

  logic [DATA_WIDTH-1:0] slot [4];
  logic [1:0]            idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 2'd0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else if (clr) begin
      idx <= 2'd0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else if (load) begin
      slot[idx] <= in_data;
      // 2-bit index wraps 3 -> 0 on the fourth byte
      idx       <= idx + 2'd1;
    end
  end

  assign word_full = (idx == 2'(IM_B));
  assign op_word   = {slot[RE_A], slot[IM_A], slot[RE_B], slot[IM_B]};

endmodule

// File: rtl/complex_nr_op_driver.sv
// Operand producer / result consumer for the complex multiplier core:
// one transaction in flight, bounded wait for the result, sticky timeout flag.
module complex_nr_op_driver
  import complex_nr_op_driver_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sw_rst,
  input  logic                             in_val,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic                             op_val,
  input  logic                             op_ready,
  output logic [4*DATA_WIDTH-1:0]          op_data,
  input  logic                             res_val,
  output logic                             res_ready,
  input  logic [res_w(DATA_WIDTH)-1:0]     res_data,
  output logic                             out_val,
  input  logic                             out_ready,
  output logic [res_w(DATA_WIDTH)-1:0]     out_data,
  output logic                             timeout_err,
  output logic [CNT_WIDTH-1:0]             done_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state;
  logic [TW-1:0]  tmo_cnt;
  logic           byte_load;
  logic           word_full;

  assign byte_load = in_val && in_ready;

  complex_op_packer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (sw_rst),
    .load     (byte_load),
    .in_data  (in_data),
    .op_word  (op_data),
    .word_full(word_full)
  );

  // Handshake outputs decode the registered state only, so no input
  // handshake signal reaches a valid/ready output combinationally.
  assign in_ready  = (state == COLLECT);
  assign op_val    = (state == ISSUE);
  assign res_ready = (state == WAIT_RES);
  assign out_val   = (state == OUTPUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      tmo_cnt     <= '0;
      out_data    <= '0;
      done_cnt    <= '0;
      timeout_err <= 1'b0;
    end else if (sw_rst) begin
      state       <= COLLECT;
      tmo_cnt     <= '0;
      out_data    <= '0;
      done_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (byte_load && word_full) state <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            state   <= WAIT_RES;
            tmo_cnt <= '0;
          end
        end
        WAIT_RES: begin
          // A result arriving on the expiry cycle takes precedence over the timeout
          if (res_val) begin
            out_data <= res_data;
            state    <= OUTPUT;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= COLLECT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            done_cnt <= done_cnt + CNT_WIDTH'(1);
            state    <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_nr_op_driver.sv
// Directed bench for complex_nr_op_driver with hand-computed expectations.
module tb_complex_nr_op_driver;

  localparam int DW = 8;
  localparam int RW = 4 * DW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sw_rst = 1'b0;
  logic          in_val = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          op_val;
  logic          op_ready = 1'b0;
  logic [4*DW-1:0] op_data;
  logic          res_val = 1'b0;
  logic          res_ready;
  logic [RW-1:0] res_data = '0;
  logic          out_val;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          timeout_err;
  logic [7:0]    done_cnt;

  int total = 0;
  int bad   = 0;

  complex_nr_op_driver #(
    .DATA_WIDTH(DW),
    .TIMEOUT   (64),
    .CNT_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst     (sw_rst),
    .in_val     (in_val),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .op_val     (op_val),
    .op_ready   (op_ready),
    .op_data    (op_data),
    .res_val    (res_val),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .out_val    (out_val),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .timeout_err(timeout_err),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bl [4];
    bl[0] = b0; bl[1] = b1; bl[2] = b2; bl[3] = b3;
    for (int i = 0; i < 4; i++) begin
      in_val  = 1'b1;
      in_data = bl[i];
      tick();
    end
    in_val = 1'b0;
  endtask

  logic seen_out;

  initial begin
    // reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_val", op_val, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_out_data", out_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // basic transaction with a 10-cycle ISSUE stall
    send_bytes(8'h03, 8'h04, 8'h05, 8'h06);
    chk("issue_op_val", op_val, 1);
    chk("issue_op_data", op_data, 32'h03040506);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_op_val", op_val, 1);
      chk("stall_op_data", op_data, 32'h03040506);
      chk("stall_in_ready", in_ready, 0);
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    chk("acc_op_val", op_val, 0);
    chk("acc_res_ready", res_ready, 1);
    res_val  = 1'b1;
    res_data = 35'h5_1234_5678;
    tick();
    res_val  = 1'b0;
    chk("out_val", out_val, 1);
    chk("out_data", out_data, 35'h5_1234_5678);
    chk("out_res_ready", res_ready, 0);

    // downstream stall; a stray result must be ignored
    res_val  = 1'b1;
    res_data = 35'h7_0000_0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ostall_out_val", out_val, 1);
      chk("ostall_out_data", out_data, 35'h5_1234_5678);
      chk("ostall_in_ready", in_ready, 0);
      chk("ostall_op_val", op_val, 0);
    end
    res_val   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_cnt_1", done_cnt, 1);
    chk("back_in_ready", in_ready, 1);
    chk("back_out_val", out_val, 0);

    // timeout: no result ever
    send_bytes(8'h10, 8'h20, 8'h30, 8'h40);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    seen_out = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (out_val) seen_out = 1'b1;
    end
    chk("tmo_not_yet", timeout_err, 0);
    chk("tmo_still_wait", res_ready, 1);
    tick();
    chk("tmo_err", timeout_err, 1);
    chk("tmo_in_ready", in_ready, 1);
    chk("tmo_res_ready", res_ready, 0);
    chk("tmo_no_out", seen_out | out_val, 0);
    chk("tmo_done_cnt", done_cnt, 1);
    tick();
    chk("tmo_sticky", timeout_err, 1);

    // software clear
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    chk("swr_timeout", timeout_err, 0);
    chk("swr_done_cnt", done_cnt, 0);
    chk("swr_out_data", out_data, 0);

    // result on the expiry cycle wins
    send_bytes(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    chk("exp_op_data", op_data, 32'hA1B2C3D4);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    res_val  = 1'b1;
    res_data = 35'h2_CAFE_F00D;
    tick();
    res_val  = 1'b0;
    chk("exp_out_val", out_val, 1);
    chk("exp_out_data", out_data, 35'h2_CAFE_F00D);
    chk("exp_timeout", timeout_err, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("exp_done_cnt", done_cnt, 1);

    // async reset mid-word
    in_val  = 1'b1;
    in_data = 8'hAA;
    tick();
    in_data = 8'hBB;
    tick();
    in_val = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_done_cnt", done_cnt, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_op_data", op_data, 0);
    #2;
    rst = 1'b0;
    send_bytes(8'h11, 8'h22, 8'h33, 8'h44);
    chk("fresh_op_val", op_val, 1);
    chk("fresh_op_data", op_data, 32'h11223344);
    op_ready = 1'b1;
    tick();

    // done_cnt wrap: 256 back-to-back transactions
    res_val   = 1'b1;
    res_data  = 35'h0_0000_00FF;
    out_ready = 1'b1;
    tick();
    tick();
    chk("wrap_first", done_cnt, 1);
    for (int n = 1; n < 255; n++) begin
      send_bytes(8'(n), 8'h01, 8'h02, 8'h03);
      tick();
      tick();
      tick();
    end
    chk("wrap_255", done_cnt, 255);
    send_bytes(8'hFE, 8'h01, 8'h02, 8'h03);
    tick();
    tick();
    tick();
    chk("wrap_0", done_cnt, 0);
    chk("wrap_no_tmo", timeout_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
